// File: rtl/mem_param.sv
// mem_param: parametrised single-port synchronous memory.
// Byte strobes, RD_LAT read pipeline, range check, zero-clear sweep after reset.
module mem_param #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                res,
   input  logic                valid,
   output logic                ready,
   input  logic                wr_rd,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                rvalid,
   output logic                err
);

   localparam int NB = DATA_W / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   state_t            state_nx;
   logic [IW-1:0]     cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              acc;
   logic              in_rng;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] rd_word;
   logic              werr_q;

   logic [RD_LAT-1:0] v_q;
   logic [RD_LAT-1:0] e_q;
   logic [DATA_W-1:0] d_q [RD_LAT];

   // Only the low IW bits select a word; upper bits only feed the range check.
   assign idx     = addr[IW-1:0];
   assign in_rng  = 32'(addr) < DEPTH;
   assign acc     = valid & ready;
   assign rd_word = in_rng ? mem[idx] : '0;

   // State register and sweep counter
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == INIT)
            cnt <= cnt + 1'b1;
      end
   end

   // Next state: leave INIT on the edge that clears the last word
   always_comb begin
      state_nx = state;
      if (state == INIT && cnt == IW'(DEPTH - 1))
         state_nx = RUN;
   end

   // Outputs decoded from state: no back-pressure once running
   always_comb begin
      ready = 1'b0;
      if (state == RUN)
         ready = 1'b1;
   end

   // Storage: zero sweep during INIT, byte-strobed writes in RUN
   always_ff @(posedge clk) begin
      if (!res) begin
         if (state == INIT) begin
            mem[cnt] <= '0;
         end else if (acc && wr_rd && in_rng) begin
            for (int i = 0; i < NB; i++)
               if (wstrb[i])
                  mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read pipeline and write-error flag; data stages only move on valid
   // so rdata keeps the last delivered word between responses.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         werr_q <= 1'b0;
         v_q    <= '0;
         e_q    <= '0;
         for (int i = 0; i < RD_LAT; i++)
            d_q[i] <= '0;
      end else begin
         werr_q <= acc & wr_rd & ~in_rng;
         v_q[0] <= acc & ~wr_rd;
         e_q[0] <= acc & ~wr_rd & ~in_rng;
         if (acc && !wr_rd)
            d_q[0] <= rd_word;
         for (int i = 1; i < RD_LAT; i++) begin
            v_q[i] <= v_q[i-1];
            e_q[i] <= e_q[i-1];
            if (v_q[i-1])
               d_q[i] <= d_q[i-1];
         end
      end
   end

   assign rvalid = v_q[RD_LAT-1];
   assign rdata  = d_q[RD_LAT-1];
   assign err    = werr_q | e_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_param.sv
// tb_mem_param: two mem_param instances (16 words/lat 1, 12 words/lat 3)
// driven with the same directed requests; scoreboard per instance.
module tb_mem_param;

   typedef struct {
      int          due;
      bit          rd;
      bit          er;
      logic [31:0] d;
   } exp_t;

   logic        clk   = 1'b0;
   logic        res   = 1'b1;
   logic        valid = 1'b0;
   logic        wr_rd = 1'b0;
   logic [7:0]  addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;

   logic        rdy0, rv0, er0;
   logic [31:0] rd0;
   logic        rdy1, rv1, er1;
   logic [31:0] rd1;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] mdl [2][16];
   logic [31:0] last [2];
   int          cyc   = 0;
   int          rel   = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   mem_param u0 (
      .clk(clk), .res(res), .valid(valid), .ready(rdy0),
      .wr_rd(wr_rd), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rdata(rd0), .rvalid(rv0), .err(er0)
   );

   mem_param #(.DEPTH(12), .RD_LAT(3)) u1 (
      .clk(clk), .res(res), .valid(valid), .ready(rdy1),
      .wr_rd(wr_rd), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rdata(rd1), .rvalid(rv1), .err(er1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk or posedge res)
      if (res) rel = 0;
      else     rel++;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(int k, exp_t e);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic model(int k, bit w, logic [7:0] a,
                        logic [31:0] d, logic [3:0] s);
      int   depth = (k == 0) ? 16 : 12;
      int   lat   = (k == 0) ? 1 : 3;
      bit   oor   = (a >= depth);
      exp_t e;
      if (w) begin
         if (oor) begin
            e.due = cyc; e.rd = 1'b0; e.er = 1'b1; e.d = '0;
            push(k, e);
         end else begin
            for (int i = 0; i < 4; i++)
               if (s[i]) mdl[k][a][8*i +: 8] = d[8*i +: 8];
         end
      end else begin
         e.due = cyc + lat - 1;
         e.rd  = 1'b1;
         e.er  = oor;
         e.d   = oor ? 32'h0 : mdl[k][a];
         push(k, e);
      end
   endtask

   task automatic mon(int k, logic rdy, logic rv, logic er, logic [31:0] rd);
      int          depth = (k == 0) ? 16 : 12;
      bit          xrdy  = 1'b0;
      bit          xrv   = 1'b0;
      bit          xer   = 1'b0;
      logic [31:0] xd;
      exp_t        q[$];
      if (res) begin
         xd = '0;
      end else begin
         xrdy = (rel >= depth);
         xd   = last[k];
         if (k == 0) q = q0;
         else        q = q1;
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
               if (q[i].due == cyc) begin
                  if (q[i].rd) begin
                     xrv = 1'b1;
                     xd  = q[i].d;
                  end
                  if (q[i].er) xer = 1'b1;
               end
               q.delete(i);
            end
         end
         if (k == 0) q0 = q;
         else        q1 = q;
      end
      chk($sformatf("u%0d ready c%0d", k, cyc), 32'(rdy), 32'(xrdy));
      chk($sformatf("u%0d rvalid c%0d", k, cyc), 32'(rv), 32'(xrv));
      chk($sformatf("u%0d err c%0d", k, cyc), 32'(er), 32'(xer));
      chk($sformatf("u%0d rdata c%0d", k, cyc), rd, xd);
      last[k] = xd;
   endtask

   always @(negedge clk) begin
      mon(0, rdy0, rv0, er0, rd0);
      mon(1, rdy1, rv1, er1, rd1);
   end

   task automatic req(bit w, logic [7:0] a, logic [31:0] d, logic [3:0] s);
      bit acc0, acc1;
      @(negedge clk);
      valid = 1'b1; wr_rd = w; addr = a; wdata = d; wstrb = s;
      acc0 = (rel >= 16);
      acc1 = (rel >= 12);
      @(posedge clk);
      #1;
      valid = 1'b0;
      if (acc0) model(0, w, a, d, s);
      if (acc1) model(1, w, a, d, s);
   endtask

   task automatic clear_model();
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         last[k] = '0;
         for (int i = 0; i < 16; i++) mdl[k][i] = '0;
      end
   endtask

   task automatic wait_run();
      while (rel < 16) @(negedge clk);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      clear_model();
      res = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      res = 1'b0;

      // requests during INIT: ignored by both, then only u1 running
      while (rel < 2) @(negedge clk);
      req(1, 8'd0, 32'hFFFF_FFFF, 4'hF);
      while (rel < 13) @(negedge clk);
      req(1, 8'd5, 32'h1234_5678, 4'hF);
      wait_run();

      // every address after the sweep
      for (int a = 0; a < 16; a++) req(0, 8'(a), 32'h0, 4'h0);

      // byte strobes
      req(1, 8'd3, 32'hAABB_CCDD, 4'hF);
      req(1, 8'd3, 32'h1122_3344, 4'b0101);
      req(0, 8'd3, 32'h0, 4'h0);

      // back-to-back reads
      req(1, 8'd1, 32'h5, 4'hF);
      req(1, 8'd2, 32'h6, 4'hF);
      req(0, 8'd1, 32'h0, 4'h0);
      req(0, 8'd2, 32'h0, 4'h0);

      // read after write
      req(1, 8'd7, 32'hDEAD_BEEF, 4'hF);
      req(0, 8'd7, 32'h0, 4'h0);

      // wstrb=0 no-op write
      req(1, 8'd3, 32'hFFFF_FFFF, 4'h0);
      req(0, 8'd3, 32'h0, 4'h0);

      // range edges: 12 valid only in u0, 15 and 200 out for u1/both
      req(1, 8'd12, 32'hCAFE_0012, 4'hF);
      req(0, 8'd12, 32'h0, 4'h0);
      req(0, 8'd15, 32'h0, 4'h0);
      req(0, 8'd11, 32'h0, 4'h0);

      // read error collides with write error in u1
      req(0, 8'd200, 32'h0, 4'h0);
      req(0, 8'd0, 32'h0, 4'h0);
      req(1, 8'd201, 32'h7777_7777, 4'hF);
      repeat (5) @(negedge clk);

      // reset while a read is in flight
      req(0, 8'd3, 32'h0, 4'h0);
      @(posedge clk);
      #2;
      res = 1'b1;
      clear_model();
      #1;
      chk("async rvalid u0", 32'(rv0), 32'h0);
      chk("async rdata u0", rd0, 32'h0);
      chk("async rvalid u1", 32'(rv1), 32'h0);
      chk("async err u1", 32'(er1), 32'h0);
      chk("async rdata u1", rd1, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      res = 1'b0;
      wait_run();
      for (int a = 0; a < 16; a++) req(0, 8'(a), 32'h0, 4'h0);
      repeat (6) @(negedge clk);

      chk("drain u0", 32'(q0.size()), 32'h0);
      chk("drain u1", 32'(q1.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
